// File: rtl/can_pkg.sv
// Shared CAN definitions for the standard-frame
// filter datapath and the multi-filter banks built on it.
package can_pkg;

  localparam int CAN_STD_ID_W = 11;

  typedef logic [CAN_STD_ID_W-1:0] can_std_id_t;

  localparam can_std_id_t CAN_ACCEPT_ALL_MASK = '0;
  localparam can_std_id_t CAN_EXACT_MASK      = '1;

endpackage

// File: rtl/can_filter_if.sv
// Bundle between receiver, filter and gateway:
// identifier strobe, filter setup and accepted output.
interface can_filter_if
  import can_pkg::*;
#(
  parameter int ID_W = CAN_STD_ID_W
) ();

  logic [ID_W-1:0] id_in;
  logic            id_valid_in;
  logic [ID_W-1:0] accept_code;
  logic [ID_W-1:0] accept_mask;
  logic            id_valid_out;
  logic [ID_W-1:0] id_out;

  modport master (
    output id_in,
    output id_valid_in,
    output accept_code,
    output accept_mask,
    input  id_valid_out,
    input  id_out
  );

  modport slave (
    input  id_in,
    input  id_valid_in,
    input  accept_code,
    input  accept_mask,
    output id_valid_out,
    output id_out
  );

endinterface

// File: rtl/can_id_match.sv
// Combinational code/mask identifier comparator.
// A mask bit of 1 forces that id bit to equal the code.
module can_id_match #(
  parameter int W = 11
) (
  input  logic [W-1:0] id,
  input  logic [W-1:0] code,
  input  logic [W-1:0] mask,
  output logic         match
);

  assign match = ~|((id ^ code) & mask);

endmodule

// File: rtl/can_filter.sv
// Single-stage acceptance filter: accepted ids
// appear one clock later, rejected ids are dropped.
module can_filter
  import can_pkg::*;
#(
  parameter int ID_W = CAN_STD_ID_W
) (
  input  logic         clk,
  input  logic         rst,
  can_filter_if.slave  bus
);

  logic            match;
  logic            accept;
  logic            valid_d;
  logic            valid_q;
  logic [ID_W-1:0] id_d;
  logic [ID_W-1:0] id_q;

  can_id_match #(
    .W (ID_W)
  ) u_match (
    .id    (bus.id_in),
    .code  (bus.accept_code),
    .mask  (bus.accept_mask),
    .match (match)
  );

  assign accept = bus.id_valid_in & match;

  // id_out keeps the last accepted id across rejects
  always_comb begin
    valid_d = accept;
    id_d    = id_q;
    if (accept) begin
      id_d = bus.id_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
    end
  end

  assign bus.id_valid_out = valid_q;
  assign bus.id_out       = id_q;

endmodule

// File: tb/tb_can_filter.sv
// Scoreboard bench for can_filter: directed cases
// followed by randomized code/mask/id traffic.
module tb_can_filter;
  import can_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  can_filter_if #(.ID_W(CAN_STD_ID_W)) bus ();

  can_filter #(
    .ID_W (CAN_STD_ID_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          due;
    logic        v;
    can_std_id_t id;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  can_std_id_t last_acc = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit ref_accept(
    input can_std_id_t id,
    input can_std_id_t code,
    input can_std_id_t mask
  );
    for (int i = 0; i < CAN_STD_ID_W; i++) begin
      if (mask[i] && (id[i] != code[i])) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drive(
    input logic        v,
    input can_std_id_t id,
    input can_std_id_t code,
    input can_std_id_t mask,
    input logic        r
  );
    logic        ev;
    can_std_id_t eid;
    @(posedge clk);
    #1;
    bus.id_valid_in = v;
    bus.id_in       = id;
    bus.accept_code = code;
    bus.accept_mask = mask;
    rst             = r;
    if (r) begin
      foreach (q[i]) begin
        q[i].v  = 1'b0;
        q[i].id = '0;
      end
      last_acc = '0;
      ev       = 1'b0;
      eid      = '0;
    end else begin
      ev = v && ref_accept(id, code, mask);
      if (ev) last_acc = id;
      eid = last_acc;
    end
    q.push_back('{cyc + 1, ev, eid});
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        n_cmp++;
        if (bus.id_valid_out !== e.v || bus.id_out !== e.id) begin
          n_bad++;
          $display("FAIL out@cyc%0d: got v=%0b id=%h, want v=%0b id=%h",
                   cyc, bus.id_valid_out, bus.id_out, e.v, e.id);
        end
      end
    end
  end

  initial begin
    can_std_id_t code;
    can_std_id_t mask;
    can_std_id_t id;
    int          mode;
    bus.id_valid_in = 1'b0;
    bus.id_in       = '0;
    bus.accept_code = '0;
    bus.accept_mask = '0;

    repeat (3) drive(1'b1, 11'h100, 11'h100, CAN_EXACT_MASK, 1'b1);

    drive(1'b1, 11'h100, 11'h100, CAN_EXACT_MASK, 1'b0);
    drive(1'b1, 11'h101, 11'h100, CAN_EXACT_MASK, 1'b0);
    drive(1'b1, 11'h200, 11'h100, CAN_EXACT_MASK, 1'b0);
    drive(1'b0, 11'h100, 11'h100, CAN_EXACT_MASK, 1'b0);

    drive(1'b1, 11'h300, 11'h300, 11'h700, 1'b0);
    drive(1'b1, 11'h310, 11'h300, 11'h700, 1'b0);
    drive(1'b1, 11'h37F, 11'h300, 11'h700, 1'b0);
    drive(1'b1, 11'h3FF, 11'h300, 11'h700, 1'b0);
    drive(1'b1, 11'h200, 11'h300, 11'h700, 1'b0);
    drive(1'b1, 11'h400, 11'h300, 11'h700, 1'b0);

    drive(1'b1, 11'h123, 11'h5A5, CAN_ACCEPT_ALL_MASK, 1'b0);
    drive(1'b1, 11'h456, 11'h5A5, CAN_ACCEPT_ALL_MASK, 1'b0);
    drive(1'b1, 11'h7FF, 11'h5A5, CAN_ACCEPT_ALL_MASK, 1'b0);

    drive(1'b1, 11'h100, 11'h100, CAN_EXACT_MASK, 1'b0);
    drive(1'b1, 11'h100, 11'h100, CAN_EXACT_MASK, 1'b1);
    drive(1'b1, 11'h100, 11'h100, CAN_EXACT_MASK, 1'b1);
    drive(1'b1, 11'h100, 11'h100, CAN_EXACT_MASK, 1'b0);
    drive(1'b1, 11'h101, 11'h100, CAN_EXACT_MASK, 1'b0);

    drive(1'b1, 11'h200, 11'h200, 11'h700, 1'b0);
    drive(1'b1, 11'h250, 11'h200, 11'h700, 1'b0);
    drive(1'b1, 11'h2AA, 11'h200, 11'h700, 1'b0);
    drive(1'b1, 11'h100, 11'h100, CAN_EXACT_MASK, 1'b0);
    drive(1'b1, 11'h101, 11'h100, CAN_EXACT_MASK, 1'b0);

    for (int n = 0; n < 400; n++) begin
      mode = int'($urandom_range(0, 3));
      code = can_std_id_t'($urandom);
      case (mode)
        0:       mask = CAN_ACCEPT_ALL_MASK;
        1:       mask = CAN_EXACT_MASK;
        default: mask = can_std_id_t'($urandom);
      endcase
      id = can_std_id_t'($urandom);
      if ($urandom_range(0, 1) == 1) id = (code & mask) | (id & ~mask);
      drive(($urandom_range(0, 3) != 0), id, code, mask,
            ($urandom_range(0, 40) == 0));
    end

    drive(1'b0, '0, '0, '0, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #6;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
